// File: rtl/data_format_adapter_state_ram_mp.sv
// Multi-read-port state RAM with same-cycle write bypass and a zeroing sweep; optional per-symbol write mask under DATA_FORMAT_ADAPTER_STATE_RAM_WRMASK_EN.
// Latency: read address sampled at edge n, data valid after edge n (registered read merged with bypass).
// Backpressure: wr_waitrequest is high during a sweep; writes presented then are dropped, not queued.
module data_format_adapter_state_ram_mp #(
  parameter int DEPTH        = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_RD_PORTS = 2,
  parameter int SYMBOL_WIDTH = 8,
  parameter int ADDR_WIDTH   = 2
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               clear,
  input  logic [ADDR_WIDTH-1:0]              wr_address,
  input  logic [DATA_WIDTH-1:0]              wr_writedata,
  input  logic                               wr_write,
`ifdef DATA_FORMAT_ADAPTER_STATE_RAM_WRMASK_EN
  input  logic [DATA_WIDTH/SYMBOL_WIDTH-1:0] wr_mask,
`endif
  output logic                               wr_waitrequest,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_address,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_readdata
);

  localparam int                    NUM_SYM   = DATA_WIDTH / SYMBOL_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   sweep_cnt_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [NUM_SYM-1:0]      wr_sym_en;
  logic                    wr_accept;

  logic                    sweep_q;
  logic [DATA_WIDTH-1:0]   byp_dat_q;
  logic [NUM_SYM-1:0]      byp_sym_q;
  logic [NUM_RD_PORTS-1:0] hit_q;
  logic [DATA_WIDTH-1:0]   rd_q [NUM_RD_PORTS];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_EXT;
  endfunction

`ifdef DATA_FORMAT_ADAPTER_STATE_RAM_WRMASK_EN
  assign wr_sym_en = wr_mask;
`else
  assign wr_sym_en = '1;
`endif

  assign wr_accept = wr_write && !wr_waitrequest && in_range(wr_address);

  // Sweep FSM: state register plus down-counter over the word addresses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_SWEEP;
      sweep_cnt_q <= LAST_ADDR;
    end else begin
      state_q <= state_d;
      if (state_q == ST_SWEEP) begin
        if (sweep_cnt_q != '0)
          sweep_cnt_q <= sweep_cnt_q - 1'b1;
      end else if (clear) begin
        sweep_cnt_q <= LAST_ADDR;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (clear)              state_d = ST_SWEEP;
      ST_SWEEP: if (sweep_cnt_q == '0)  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_waitrequest = (state_q == ST_SWEEP);
  end

  // Storage is not reset; the sweep establishes its contents.
  always_ff @(posedge clk) begin
    if (wr_waitrequest) begin
      mem[sweep_cnt_q] <= '0;
    end else if (wr_accept) begin
      for (int s = 0; s < NUM_SYM; s++)
        if (wr_sym_en[s])
          mem[wr_address][s*SYMBOL_WIDTH +: SYMBOL_WIDTH] <= wr_writedata[s*SYMBOL_WIDTH +: SYMBOL_WIDTH];
    end
  end

  // Read stage: pre-write memory word plus the same-edge write, merged on the output side.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sweep_q   <= 1'b1;
      byp_dat_q <= '0;
      byp_sym_q <= '0;
      hit_q     <= '0;
      for (int k = 0; k < NUM_RD_PORTS; k++)
        rd_q[k] <= '0;
    end else begin
      sweep_q   <= wr_waitrequest;
      byp_dat_q <= wr_writedata;
      byp_sym_q <= wr_sym_en;
      for (int k = 0; k < NUM_RD_PORTS; k++) begin
        hit_q[k] <= wr_accept && (wr_address == rd_address[k*ADDR_WIDTH +: ADDR_WIDTH]);
        rd_q[k]  <= in_range(rd_address[k*ADDR_WIDTH +: ADDR_WIDTH])
                    ? mem[rd_address[k*ADDR_WIDTH +: ADDR_WIDTH]] : '0;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
    logic [DATA_WIDTH-1:0] merged;

    always_comb begin
      merged = rd_q[k];
      for (int s = 0; s < NUM_SYM; s++)
        if (hit_q[k] && byp_sym_q[s])
          merged[s*SYMBOL_WIDTH +: SYMBOL_WIDTH] = byp_dat_q[s*SYMBOL_WIDTH +: SYMBOL_WIDTH];
      if (sweep_q)
        merged = '0;
    end

    assign rd_readdata[k*DATA_WIDTH +: DATA_WIDTH] = merged;
  end

endmodule

// File: tb/tb_data_format_adapter_state_ram_mp.sv
// Directed bench for data_format_adapter_state_ram_mp (DEPTH=4, two read ports).
module tb_data_format_adapter_state_ram_mp;

`ifdef DATA_FORMAT_ADAPTER_STATE_RAM_WRMASK_EN
  localparam int DW = 16;
`else
  localparam int DW = 8;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clear;
  logic [1:0]    wr_address;
  logic [DW-1:0] wr_writedata;
  logic          wr_write;
`ifdef DATA_FORMAT_ADAPTER_STATE_RAM_WRMASK_EN
  logic [1:0]    wr_mask;
`endif
  logic          wr_waitrequest;
  logic [3:0]    rd_address;
  logic [2*DW-1:0] rd_readdata;

  int errs   = 0;
  int checks = 0;
  int n;

  data_format_adapter_state_ram_mp #(
    .DEPTH(4), .DATA_WIDTH(DW), .NUM_RD_PORTS(2), .SYMBOL_WIDTH(8), .ADDR_WIDTH(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .clear(clear),
    .wr_address(wr_address),
    .wr_writedata(wr_writedata),
    .wr_write(wr_write),
`ifdef DATA_FORMAT_ADAPTER_STATE_RAM_WRMASK_EN
    .wr_mask(wr_mask),
`endif
    .wr_waitrequest(wr_waitrequest),
    .rd_address(rd_address),
    .rd_readdata(rd_readdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [1:0] a0, input logic [1:0] a1);
    rd_address = {a1, a0};
  endtask

  task automatic set_wr(input logic we, input logic [1:0] a, input logic [DW-1:0] d);
    wr_write     = we;
    wr_address   = a;
    wr_writedata = d;
  endtask

  function automatic logic [DW-1:0] rdp(input int k);
    return rd_readdata[k*DW +: DW];
  endfunction

  // Edges until wr_waitrequest reads low, bounded at 20.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (wr_waitrequest && cnt < 20);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    clear   = 1'b0;
    set_wr(1'b0, 2'd0, '0);
`ifdef DATA_FORMAT_ADAPTER_STATE_RAM_WRMASK_EN
    wr_mask = 2'b11;
`endif
    set_rd(2'd0, 2'd0);
    tick();
    tick();
    chk("reset_waitreq", 32'(wr_waitrequest), 32'd1);
    chk("reset_rddata", 32'(rd_readdata), 32'd0);

    reset_n = 1'b1;
    wait_ready(n);
    chk("init_sweep_len", 32'(n), 32'd4);

    for (int a = 0; a < 4; a++) begin
      set_rd(2'(a), 2'(a));
      tick();
      chk($sformatf("init_rd%0d_p0", a), 32'(rdp(0)), 32'd0);
      chk($sformatf("init_rd%0d_p1", a), 32'(rdp(1)), 32'd0);
    end

    // Same-edge bypass on port 0, then port 1 from memory.
    set_wr(1'b1, 2'd2, DW'('hA5));
    set_rd(2'd2, 2'd0);
    tick();
    chk("byp_p0_a5", 32'(rdp(0)), 32'hA5);
    set_wr(1'b0, 2'd0, '0);
    set_rd(2'd2, 2'd2);
    tick();
    chk("mem_p1_a5", 32'(rdp(1)), 32'hA5);

    set_wr(1'b1, 2'd1, DW'('h11));
    tick();
    set_wr(1'b1, 2'd3, DW'('h33));
    set_rd(2'd1, 2'd3);
    tick();
    chk("indep_p0_11", 32'(rdp(0)), 32'h11);
    chk("indep_p1_33", 32'(rdp(1)), 32'h33);

    set_wr(1'b1, 2'd2, DW'('h77));
    set_rd(2'd2, 2'd2);
    tick();
    chk("both_byp_p0", 32'(rdp(0)), 32'h77);
    chk("both_byp_p1", 32'(rdp(1)), 32'h77);

    // Runtime clear with a write attempted throughout the sweep.
    set_wr(1'b1, 2'd0, DW'('h5A));
    tick();
    set_wr(1'b0, 2'd0, '0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_waitreq", 32'(wr_waitrequest), 32'd1);
    n = 1;
    set_wr(1'b1, 2'd3, DW'('hFF));
    set_rd(2'd0, 2'd3);
    tick();
    chk("sweep_rd_zero", 32'(rdp(1)), 32'd0);
    if (wr_waitrequest) n++;
    for (int i = 0; i < 20 && wr_waitrequest; i++) begin
      tick();
      if (wr_waitrequest) n++;
    end
    set_wr(1'b0, 2'd0, '0);
    chk("clear_sweep_len", 32'(n), 32'd4);
    tick();
    chk("clear_a0_zero", 32'(rdp(0)), 32'd0);
    chk("dropped_a3_zero", 32'(rdp(1)), 32'd0);

    // Reset asserted on the second sweep cycle.
    set_wr(1'b1, 2'd2, DW'('h42));
    tick();
    set_wr(1'b0, 2'd0, '0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    set_rd(2'd2, 2'd1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_waitreq", 32'(wr_waitrequest), 32'd1);
    chk("midrst_rddata", 32'(rd_readdata), 32'd0);
    tick();
    chk("midrst_hold", 32'(wr_waitrequest), 32'd1);
    reset_n = 1'b1;
    wait_ready(n);
    chk("midrst_sweep_len", 32'(n), 32'd4);
    tick();
    chk("midrst_a2_zero", 32'(rdp(0)), 32'd0);

`ifdef DATA_FORMAT_ADAPTER_STATE_RAM_WRMASK_EN
    wr_mask = 2'b11;
    set_wr(1'b1, 2'd1, 16'h1234);
    tick();
    wr_mask = 2'b01;
    set_wr(1'b1, 2'd1, 16'hABCD);
    set_rd(2'd1, 2'd0);
    tick();
    chk("mask_byp", 32'(rdp(0)), 32'h12CD);
    set_wr(1'b0, 2'd0, '0);
    tick();
    chk("mask_mem", 32'(rdp(0)), 32'h12CD);
    wr_mask = 2'b00;
    set_wr(1'b1, 2'd1, 16'hFFFF);
    tick();
    chk("mask_zero_byp", 32'(rdp(0)), 32'h12CD);
    set_wr(1'b0, 2'd0, '0);
    tick();
    chk("mask_zero_mem", 32'(rdp(0)), 32'h12CD);
`else
    set_wr(1'b1, 2'd1, 8'h12);
    tick();
    set_wr(1'b1, 2'd1, 8'hCD);
    set_rd(2'd1, 2'd0);
    tick();
    chk("full_byp", 32'(rdp(0)), 32'hCD);
    set_wr(1'b0, 2'd0, '0);
    tick();
    chk("full_mem", 32'(rdp(0)), 32'hCD);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
